// File: rtl/idli_sqi_seq_m.sv
// SQI transaction sequencer: turns 32-bit line read/write requests into
// quad-I/O bus cycles on SQI_NUM parallel serial SRAMs and returns read words.
// Each chip carries one nibble of every 16-bit word (chip i = bits [4i+3:4i]).

package idli_pkg;
    localparam int SQI_NUM = 4;
    typedef logic [3:0] sqi_data_t;
    typedef sqi_data_t [SQI_NUM-1:0] sqi_bus_t;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DESEL = 3'd5
    } seq_state_e;
endpackage

// Request handshake: a request transfers on a rising gck edge where
// i_seq_req_vld and o_seq_req_rdy are both 1. rdy is high only in IDLE, and
// the request inputs are ignored whenever rdy is low. The response side has
// no backpressure: o_seq_rsp_vld is a single-gck pulse per returned word.
module idli_sqi_seq_m
    import idli_pkg::*;
#(
    parameter int DESEL_SQI = 1
) (
    input  logic        i_seq_gck,
    input  logic        i_seq_rst_n,
    input  logic        i_seq_req_vld,
    output logic        o_seq_req_rdy,
    input  logic        i_seq_req_wr,
    input  logic [15:0] i_seq_req_addr,
    input  logic [31:0] i_seq_req_data,
    output logic        o_seq_rsp_vld,
    output logic [15:0] o_seq_rsp_data,
    output logic        o_seq_sck,
    output logic        o_seq_cs,
    input  sqi_bus_t    i_seq_sio,
    output sqi_bus_t    o_seq_sio,
    output logic        o_seq_sio_oe,
    output seq_state_e  o_seq_state
);

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [2:0] DESEL_LAST = 3'(DESEL_SQI - 1);

    seq_state_e  state;
    logic        phase;      // 0: sck low half, 1: sck high half
    logic [2:0]  cnt;        // nibble index within the current state
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] data_q;

    logic [23:0] byte_addr;
    logic [7:0]  cmd_byte;
    logic [7:0]  accept_cmd;

    // Return nibble idx (0 = most significant) of the 24-bit byte address.
    function automatic sqi_data_t addr_nib(input logic [23:0] a, input logic [2:0] idx);
        case (idx)
            3'd0:    return a[23:20];
            3'd1:    return a[19:16];
            3'd2:    return a[15:12];
            3'd3:    return a[11:8];
            3'd4:    return a[7:4];
            3'd5:    return a[3:0];
            default: return 4'h0;
        endcase
    endfunction

    // Command and address phases put the same nibble on every chip.
    function automatic sqi_bus_t bcast(input sqi_data_t nib);
        return {SQI_NUM{nib}};
    endfunction

    // Word address to byte address: drop bit 0 (line granularity) and zero-extend.
    always_comb begin
        byte_addr  = 24'({8'h00, addr_q} >> 1);
        cmd_byte   = wr_q ? CMD_WRITE : CMD_READ;
        accept_cmd = i_seq_req_wr ? CMD_WRITE : CMD_READ;
    end

    assign o_seq_state = state;

    // Sequencer FSM: all pin outputs are registered and change only at the
    // edge that starts phase 0, except sck which toggles every gck while selected.
    always_ff @(posedge i_seq_gck or negedge i_seq_rst_n) begin
        if (!i_seq_rst_n) begin
            state          <= ST_IDLE;
            phase          <= 1'b0;
            cnt            <= 3'd0;
            wr_q           <= 1'b0;
            addr_q         <= 16'h0000;
            data_q         <= 32'h0000_0000;
            o_seq_req_rdy  <= 1'b1;
            o_seq_rsp_vld  <= 1'b0;
            o_seq_rsp_data <= 16'h0000;
            o_seq_sck      <= 1'b0;
            o_seq_cs       <= 1'b1;
            o_seq_sio      <= '0;
            o_seq_sio_oe   <= 1'b0;
        end else begin
            o_seq_rsp_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    phase     <= 1'b0;
                    o_seq_sck <= 1'b0;
                    if (i_seq_req_vld) begin
                        wr_q          <= i_seq_req_wr;
                        addr_q        <= i_seq_req_addr;
                        data_q        <= i_seq_req_data;
                        state         <= ST_CMD;
                        cnt           <= 3'd0;
                        o_seq_req_rdy <= 1'b0;
                        o_seq_cs      <= 1'b0;
                        o_seq_sio_oe  <= 1'b1;
                        o_seq_sio     <= bcast(accept_cmd[7:4]);
                    end
                end
                default: begin
                    phase <= ~phase;
                    if (!phase) begin
                        // End of phase 0: sck rises, read data is captured.
                        o_seq_sck <= (state != ST_DESEL);
                        if (state == ST_DATA && !wr_q) begin
                            o_seq_rsp_vld  <= 1'b1;
                            o_seq_rsp_data <= i_seq_sio;
                        end
                    end else begin
                        // End of phase 1: sck falls, next nibble is launched.
                        o_seq_sck <= 1'b0;
                        cnt       <= cnt + 3'd1;
                        case (state)
                            ST_CMD: begin
                                if (cnt == 3'd0) begin
                                    o_seq_sio <= bcast(cmd_byte[3:0]);
                                end else begin
                                    state     <= ST_ADDR;
                                    cnt       <= 3'd0;
                                    o_seq_sio <= bcast(addr_nib(byte_addr, 3'd0));
                                end
                            end
                            ST_ADDR: begin
                                if (cnt != 3'd5) begin
                                    o_seq_sio <= bcast(addr_nib(byte_addr, cnt + 3'd1));
                                end else if (wr_q) begin
                                    state     <= ST_DATA;
                                    cnt       <= 3'd0;
                                    o_seq_sio <= data_q[15:0];
                                end else begin
                                    state        <= ST_DUMMY;
                                    cnt          <= 3'd0;
                                    o_seq_sio_oe <= 1'b0;
                                    o_seq_sio    <= '0;
                                end
                            end
                            ST_DUMMY: begin
                                if (cnt == 3'd1) begin
                                    state <= ST_DATA;
                                    cnt   <= 3'd0;
                                end
                            end
                            ST_DATA: begin
                                if (cnt == 3'd0) begin
                                    if (wr_q) begin
                                        o_seq_sio <= data_q[31:16];
                                    end
                                end else begin
                                    state        <= ST_DESEL;
                                    cnt          <= 3'd0;
                                    o_seq_cs     <= 1'b1;
                                    o_seq_sio_oe <= 1'b0;
                                    o_seq_sio    <= '0;
                                end
                            end
                            ST_DESEL: begin
                                if (cnt == DESEL_LAST) begin
                                    state         <= ST_IDLE;
                                    cnt           <= 3'd0;
                                    o_seq_req_rdy <= 1'b1;
                                end
                            end
                            default: begin
                                state         <= ST_IDLE;
                                cnt           <= 3'd0;
                                o_seq_req_rdy <= 1'b1;
                                o_seq_cs      <= 1'b1;
                                o_seq_sio_oe  <= 1'b0;
                                o_seq_sio     <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_seq_m.sv
// Bench for idli_sqi_seq_m: directed read/write/busy/reset vectors on a
// DESEL_SQI=1 instance, plus a DESEL_SQI=3 instance run back-to-back.

module tb_idli_sqi_seq_m;
    import idli_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    int acc_edge = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- DUT (DESEL_SQI = 1) ----------------
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_data = 32'h0;
    logic        rsp_vld;
    logic [15:0] rsp_data;
    logic        sck, cs, sio_oe;
    sqi_bus_t    sio_in = '0;
    sqi_bus_t    sio_out;
    seq_state_e  st;

    idli_sqi_seq_m #(.DESEL_SQI(1)) dut (
        .i_seq_gck      (clk),
        .i_seq_rst_n    (rst_n),
        .i_seq_req_vld  (req_vld),
        .o_seq_req_rdy  (req_rdy),
        .i_seq_req_wr   (req_wr),
        .i_seq_req_addr (req_addr),
        .i_seq_req_data (req_data),
        .o_seq_rsp_vld  (rsp_vld),
        .o_seq_rsp_data (rsp_data),
        .o_seq_sck      (sck),
        .o_seq_cs       (cs),
        .i_seq_sio      (sio_in),
        .o_seq_sio      (sio_out),
        .o_seq_sio_oe   (sio_oe),
        .o_seq_state    (st)
    );

    // ---------------- DUT (DESEL_SQI = 3), request held valid ----------------
    logic        rdy3, rsp_vld3, sck3, cs3, oe3;
    logic [15:0] rsp_data3;
    sqi_bus_t    sio_out3;
    seq_state_e  st3;

    idli_sqi_seq_m #(.DESEL_SQI(3)) dut3 (
        .i_seq_gck      (clk),
        .i_seq_rst_n    (rst_n),
        .i_seq_req_vld  (1'b1),
        .o_seq_req_rdy  (rdy3),
        .i_seq_req_wr   (1'b0),
        .i_seq_req_addr (16'h0010),
        .i_seq_req_data (32'h0),
        .o_seq_rsp_vld  (rsp_vld3),
        .o_seq_rsp_data (rsp_data3),
        .o_seq_sck      (sck3),
        .o_seq_cs       (cs3),
        .i_seq_sio      (16'h0000),
        .o_seq_sio      (sio_out3),
        .o_seq_sio_oe   (oe3),
        .o_seq_state    (st3)
    );

    // ---------------- counters / check helper ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Counts sck rising edges since cs fell; read words are driven during
    // SQI cycles 10 and 11 (after 2 cmd + 6 addr + 2 dummy), junk otherwise.
    logic [15:0] mem_w0 = 16'h0, mem_w1 = 16'h0;
    int rise_cnt = 0;
    logic prev_sck = 1'b0;
    always @(negedge clk) begin
        if (cs) begin
            rise_cnt = 0;
            prev_sck = 1'b0;
        end else begin
            if (sck && !prev_sck) rise_cnt++;
            prev_sck = sck;
        end
        if (!cs && rise_cnt == 10)      sio_in = mem_w0;
        else if (!cs && rise_cnt == 11) sio_in = mem_w1;
        else                            sio_in = 16'($urandom);
    end

    // ---------------- pin logger (index = cycle after accept) ----------------
    logic        cs_log  [64];
    logic        sck_log [64];
    logic        oe_log  [64];
    logic        rdy_log [64];
    logic [15:0] sio_log [64];
    always @(negedge clk) begin
        int rel;
        rel = cyc_cnt - acc_edge;
        if (rel >= 0 && rel < 64) begin
            cs_log[rel]  = cs;
            sck_log[rel] = sck;
            oe_log[rel]  = sio_oe;
            rdy_log[rel] = req_rdy;
            sio_log[rel] = sio_out;
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];

    task automatic expect_rsp(input logic [15:0] d, input int c);
        exp_q.push_back(d);
        exp_cyc_q.push_back(c);
    endtask

    always @(negedge clk) begin
        if (rsp_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_vld with data %0h expected no response", rsp_data);
            end else begin
                logic [15:0] ed;
                int ec;
                ed = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(ed));
                chk("rsp_cycle", 32'(cyc_cnt - acc_edge), 32'(ec));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk);
        req_wr   = wr;
        req_addr = addr;
        req_data = data;
        req_vld  = 1'b1;
        n = 0;
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got rdy=0 after %0d cycles expected rdy=1", n);
            req_vld = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_edge = cyc_cnt - 1;
        req_vld  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic cs3_log [100];

    initial begin
        int f1, f2, hi, n, rel_rdy;
        logic [15:0] addr_exp [6];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_oe", 32'(sio_oe), 32'd0);
        chk("rst_sio", 32'(sio_out), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd1);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_state", 32'(st), 32'(ST_IDLE));
        rst_n = 1'b1;

        // DESEL_SQI = 3 instance: back-to-back reads with vld held high
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cs3_log[i] = cs3;
        end
        f1 = -1;
        f2 = -1;
        for (int i = 1; i < 100; i++) begin
            if (cs3_log[i-1] && !cs3_log[i]) begin
                if (f1 < 0)      f1 = i;
                else if (f2 < 0) f2 = i;
            end
        end
        if (f1 < 0 || f2 < 0) begin
            checks++;
            errors++;
            $display("FAIL desel3_edges: got falls at %0d,%0d expected two cs falls", f1, f2);
        end else begin
            hi = 0;
            for (int i = f1; i < f2; i++) if (cs3_log[i]) hi++;
            // 3 SQI cycles of DESEL (6 gck) plus the single IDLE accept cycle
            chk("desel3_cs_high", 32'(hi), 32'd7);
            chk("desel3_period", 32'(f2 - f1), 32'd31);
        end

        // Read addr 0x1235 -> words 0xA5C3, 0x1F2E
        mem_w0 = 16'hA5C3;
        mem_w1 = 16'h1F2E;
        expect_rsp(16'hA5C3, 22);
        expect_rsp(16'h1F2E, 24);
        send(1'b0, 16'h1235, 32'h0);
        repeat (30) @(negedge clk);
        chk("rd_cmd0", 32'(sio_log[1]), 32'h0000);
        chk("rd_cmd0_hold", 32'(sio_log[2]), 32'h0000);
        chk("rd_cmd1", 32'(sio_log[3]), 32'h3333);
        addr_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h9999, 16'h1111, 16'hAAAA};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rd_addr%0d", k), 32'(sio_log[5 + 2*k]), 32'(addr_exp[k]));
            chk($sformatf("rd_addr%0d_hold", k), 32'(sio_log[6 + 2*k]), 32'(addr_exp[k]));
        end
        for (int k = 1; k <= 24; k++) begin
            chk($sformatf("rd_cs_c%0d", k), 32'(cs_log[k]), 32'd0);
            chk($sformatf("rd_sck_c%0d", k), 32'(sck_log[k]), 32'(k % 2 == 0));
            chk($sformatf("rd_oe_c%0d", k), 32'(oe_log[k]), 32'(k <= 16));
            chk($sformatf("rd_rdy_c%0d", k), 32'(rdy_log[k]), 32'd0);
        end
        for (int k = 17; k <= 24; k++)
            chk($sformatf("rd_sio_idle_c%0d", k), 32'(sio_log[k]), 32'd0);
        for (int k = 25; k <= 27; k++) begin
            chk($sformatf("rd_desel_cs_c%0d", k), 32'(cs_log[k]), 32'd1);
            chk($sformatf("rd_desel_sck_c%0d", k), 32'(sck_log[k]), 32'd0);
        end
        chk("rd_rdy_c26", 32'(rdy_log[26]), 32'd0);
        chk("rd_rdy_c27", 32'(rdy_log[27]), 32'd1);

        // Write addr 0x0002, data 0xBEEF_1234 (no response expected)
        send(1'b1, 16'h0002, 32'hBEEF_1234);
        repeat (26) @(negedge clk);
        chk("wr_cmd0", 32'(sio_log[1]), 32'h0000);
        chk("wr_cmd1", 32'(sio_log[3]), 32'h2222);
        addr_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1111};
        for (int k = 0; k < 6; k++)
            chk($sformatf("wr_addr%0d", k), 32'(sio_log[5 + 2*k]), 32'(addr_exp[k]));
        chk("wr_data0", 32'(sio_log[17]), 32'h1234);
        chk("wr_data0_hold", 32'(sio_log[18]), 32'h1234);
        chk("wr_data1", 32'(sio_log[19]), 32'hBEEF);
        chk("wr_data1_hold", 32'(sio_log[20]), 32'hBEEF);
        for (int k = 1; k <= 20; k++)
            chk($sformatf("wr_oe_c%0d", k), 32'(oe_log[k]), 32'd1);
        chk("wr_desel_cs_c21", 32'(cs_log[21]), 32'd1);
        chk("wr_desel_oe_c21", 32'(oe_log[21]), 32'd0);
        chk("wr_desel_sio_c21", 32'(sio_log[21]), 32'd0);
        chk("wr_rdy_c22", 32'(rdy_log[22]), 32'd0);
        chk("wr_rdy_c23", 32'(rdy_log[23]), 32'd1);

        // Request while busy: vld raised in cycle 3, accepted at end of cycle 27
        mem_w0 = 16'h0F0F;
        mem_w1 = 16'h7E81;
        expect_rsp(16'h0F0F, 22);
        expect_rsp(16'h7E81, 24);
        send(1'b0, 16'h0100, 32'h0);
        repeat (3) @(negedge clk);
        req_wr   = 1'b0;
        req_addr = 16'h0040;
        req_vld  = 1'b1;
        n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        rel_rdy = cyc_cnt - acc_edge;
        chk("busy_accept_cycle", 32'(rel_rdy), 32'd27);
        @(posedge clk);
        #1;
        acc_edge = cyc_cnt - 1;
        req_vld  = 1'b0;
        expect_rsp(16'h0F0F, 22);
        expect_rsp(16'h7E81, 24);
        @(negedge clk);
        chk("busy_second_cs", 32'(cs), 32'd0);
        chk("busy_second_state", 32'(st), 32'(ST_CMD));
        chk("busy_second_rdy", 32'(req_rdy), 32'd0);
        repeat (30) @(negedge clk);

        // Asynchronous reset in the middle of ADDR
        send(1'b0, 16'h1235, 32'h0);
        repeat (8) @(negedge clk);
        chk("midrst_pre_state", 32'(st), 32'(ST_ADDR));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", 32'(cs), 32'd1);
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_oe", 32'(sio_oe), 32'd0);
        chk("midrst_sio", 32'(sio_out), 32'd0);
        chk("midrst_rdy", 32'(req_rdy), 32'd1);
        chk("midrst_state", 32'(st), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_state", 32'(st), 32'(ST_IDLE));
        chk("postrst_rdy", 32'(req_rdy), 32'd1);
        chk("postrst_cs", 32'(cs), 32'd1);

        chk("rsp_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
